// File: rtl/m_shiftseq.sv
// m_shiftseq: multi-cycle shift sequencer (SLL/SRL/SRA and byte-lane align).
// Shifts a 32-bit operand by one bit per clock under a 5-bit down counter,
// with valid/ready handshakes on both the request and the result side.
module m_shiftseq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [4:0]      req_amt,
    input  logic [XLEN-1:0] req_data,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            busy,
    output logic [4:0]      dbg_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL   = 2'b00,
        OP_SRL   = 2'b01,
        OP_SRA   = 2'b10,
        OP_ALIGN = 2'b11
    } op_e;

    state_e          state_q;
    op_e             op_q;
    logic [XLEN-1:0] data_q;
    logic [4:0]      cnt_q;
    logic            res_valid_q;
    logic            busy_q;

    logic [4:0]      amt_d;
    logic [XLEN-1:0] shift_d;

    // Effective shift amount of the incoming request; align shifts whole bytes.
    always_comb begin
        amt_d = req_amt;
        if (op_e'(req_op) == OP_ALIGN) begin
            amt_d = {req_amt[1:0], 3'b000};
        end
    end

    // One-bit shift of the working register according to the latched op.
    always_comb begin
        shift_d = data_q;
        case (op_q)
            OP_SRL:  shift_d = {1'b0, data_q[XLEN-1:1]};
            OP_SRA:  shift_d = {data_q[XLEN-1], data_q[XLEN-1:1]};
            default: shift_d = {data_q[XLEN-2:0], 1'b0};
        endcase
    end

    // Sequencer FSM with registered handshake/status outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SLL;
            data_q      <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            // Abort wins over everything; data and counter are left as-is.
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        data_q <= req_data;
                        op_q   <= op_e'(req_op);
                        cnt_q  <= amt_d;
                        busy_q <= 1'b1;
                        if (amt_d == 5'd0) begin
                            state_q     <= S_DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q <= shift_d;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q     <= S_DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = data_q;
    assign busy      = busy_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_m_shiftseq.sv
// tb_m_shiftseq: directed and randomized checks of m_shiftseq against an
// arithmetic reference of the shift operations and handshake timing.
module tb_m_shiftseq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_amt;
    logic [31:0] req_data;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic [4:0]  dbg_cnt;

    int errors = 0;
    int checks = 0;

    m_shiftseq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_amt   (req_amt),
        .req_data  (req_data),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .dbg_cnt   (dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned eff_amt(input logic [1:0] op, input logic [4:0] amt);
        if (op == 2'b11) return 8 * int'(amt[1:0]);
        return int'(amt);
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [4:0] amt,
                                               input logic [31:0] d);
        logic signed [31:0] s;
        int unsigned n;
        s = d;
        n = eff_amt(op, amt);
        case (op)
            2'b01:   return d >> n;
            2'b10:   return s >>> n;
            default: return d << n;
        endcase
    endfunction

    // Complete transaction: accept, per-cycle shift phase, result, optional
    // backpressure of `hold` cycles, then handshake and return to idle.
    task automatic run_txn(input logic [1:0] op, input logic [4:0] amt,
                           input logic [31:0] d, input int unsigned hold);
        int unsigned n;
        logic [31:0] exp;
        n   = eff_amt(op, amt);
        exp = ref_result(op, amt, d);
        check("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_amt   = amt;
        req_data  = d;
        res_ready = (hold == 0);
        tick();
        req_valid = 1'b0;
        req_data  = $urandom;
        for (int unsigned i = 0; i < n; i++) begin
            check("shift_res_valid", res_valid, 0);
            check("shift_req_ready", req_ready, 0);
            check("shift_busy", busy, 1);
            check("shift_dbg_cnt", dbg_cnt, n - i);
            tick();
        end
        check("done_res_valid", res_valid, 1);
        check("done_res_data", res_data, exp);
        check("done_dbg_cnt", dbg_cnt, 0);
        check("done_busy", busy, 1);
        for (int unsigned h = 0; h < hold; h++) begin
            tick();
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp);
            check("hold_req_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        check("after_req_ready", req_ready, 1);
        check("after_res_valid", res_valid, 0);
        check("after_busy", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_amt   = 5'd0;
        req_data  = 32'h0;
        flush     = 1'b0;
        res_ready = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res_data", res_data, 0);
        check("rst_dbg_cnt", dbg_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_txn(2'b10, 5'd4,  32'h80000000, 0);
        check("sra_value", res_data, 32'hF8000000);
        run_txn(2'b00, 5'd31, 32'h00000001, 0);
        check("sll31_value", res_data, 32'h80000000);
        run_txn(2'b01, 5'd0,  32'hDEADBEEF, 0);
        check("srl0_value", res_data, 32'hDEADBEEF);
        run_txn(2'b01, 5'd31, 32'h80000000, 0);
        check("srl31_value", res_data, 32'h00000001);
        run_txn(2'b11, 5'b11111, 32'h000000AB, 0);
        check("align24_value", res_data, 32'hAB000000);
        run_txn(2'b11, 5'b11100, 32'h000000AB, 0);
        check("align0_value", res_data, 32'h000000AB);
        run_txn(2'b10, 5'd7, 32'h12345678, 10);

        // Flush in the middle of an SLL by 20.
        req_valid = 1'b1; req_op = 2'b00; req_amt = 5'd20; req_data = 32'h00000003;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_req_ready", req_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_res_valid", res_valid, 0);
        check("flush_dbg_cnt", dbg_cnt, 18);
        check("flush_res_data", res_data, 32'h0000000C);
        for (int k = 0; k < 25; k++) begin
            tick();
            check("flush_no_result", res_valid, 0);
        end

        // Flush takes priority over a request presented in IDLE.
        req_valid = 1'b1; req_op = 2'b00; req_amt = 5'd3; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", req_ready, 1);
        check("flush_blocks_busy", busy, 0);
        run_txn(2'b00, 5'd5, 32'h0000FFFF, 2);

        // Asynchronous reset during SHIFT.
        req_valid = 1'b1; req_op = 2'b01; req_amt = 5'd12; req_data = 32'hCAFEF00D;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_res_valid", res_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_res_data", res_data, 0);
        check("arst_dbg_cnt", dbg_cnt, 0);
        #3;
        rst_n = 1'b1;
        tick();

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            run_txn(2'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_shiftseq.md
# m_shiftseq

Multi-cycle shift sequencer for midgetv, which has no barrel shifter. It accepts a shift request over a valid/ready handshake and shifts a 32-bit operand one bit per clock, using an internal 5-bit down counter. It then presents the result over a second valid/ready handshake. It sits beside the ALU and serves SLL/SRL/SRA, plus byte-lane alignment for sub-word stores.

## Interface
- XLEN, 32, operand width; only 32 is supported, and the shift amount is 5 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  a request is present.
- req_ready  out  1  the sequencer can accept a request; high only in IDLE.
- req_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 byte-align (SLL by {req_amt[1:0],3'b000}).
- req_amt  in  5  shift amount; for op 11 only bits [1:0] are used.
- req_data  in  XLEN  operand.
- flush  in  1  synchronous abort; returns to IDLE.
- res_valid  out  1  the result is valid.
- res_ready  in  1  the consumer takes the result.
- res_data  out  XLEN  result register.
- busy  out  1  high in SHIFT or DONE.
- dbg_cnt  out  5  current counter value.

## Operation
- States:
  - IDLE: req_ready=1.
  - SHIFT: one bit per cycle.
  - DONE: res_valid=1.
- Accept occurs when req_valid & req_ready.
  - Load res_data←req_data, op←req_op and cnt←effective amount.
  - Effective amount is req_amt for ops 00/01/10 and {req_amt[1:0],3'b000} for op 11.
  - Next state is SHIFT if the effective amount ≠0, otherwise DONE.
- SHIFT, each cycle:
  - SLL/align: res_data←{res_data[30:0],1'b0}.
  - SRL: res_data←{1'b0,res_data[31:1]}.
  - SRA: res_data←{res_data[31],res_data[31:1]}.
  - cnt←cnt−1.
  - When cnt==1 this is the last shift and the next state is DONE.
- DONE: res_data is held stable. On res_valid & res_ready the next state is IDLE.
- flush=1 forces the next state to IDLE from any state.
  - It has priority over accept, shift and result handshake.
  - res_data and cnt are left unchanged.
- cnt never wraps: a decrement happens only in SHIFT, where cnt≥1.
- Op 11 ignores req_amt[4:2]. The effective amount is one of 0, 8, 16 or 24.
- Reset values (async, on rst_n=0):
  - state=IDLE, so req_ready=1.
  - res_valid=0, busy=0.
  - res_data=0, cnt=0.
  - Reset mid-operation discards the operation with no result.

## Timing
- Accept in cycle T with effective amount n:
  - res_valid rises at T+1+n.
  - Amount 0 gives the result at T+1.
- req_ready is low from T+1 until the cycle after the result handshake. There is no same-cycle result-to-request turnaround.
- The minimum request-to-request period is n+2 cycles when res_ready is held high.
- res_valid, res_data and busy are registered outputs. req_ready is decoded from state only and has no combinational path from inputs.
- Backpressure: res_valid stays high and res_data stays stable for as long as res_ready is low. Hold is unbounded.
- flush in cycle F: req_ready=1 at F+1. A req_valid in cycle F is not accepted, even though req_ready is high in IDLE.
- dbg_cnt equals the number of shifts remaining.

## Test plan
- SRA, req_data=0x80000000, amt=4, accept at T, res_ready=1 → res_valid at T+5, res_data=0xF8000000; req_ready=1 at T+6.
- SLL, req_data=0x00000001, amt=31 → res_data=0x80000000 at T+32; dbg_cnt steps 31,30,…,1 during T+1…T+31.
- SRL, amt=0, req_data=0xDEADBEEF → res_valid at T+1 with 0xDEADBEEF; SRL 0x80000000 by 31 → 0x00000001 at T+32.
- Op 11, amt=5'b11111, req_data=0x000000AB → effective 24, res_data=0xAB000000 at T+25; amt[1:0]=00 → result at T+1, unchanged.
- Backpressure: res_ready=0 for 10 cycles after res_valid → res_valid and res_data stable, req_ready=0 throughout; the single-cycle res_ready completes the handshake, and req_ready=1 the next cycle.
- flush at T+3 of an SLL by 20 → req_ready=1 at T+4 and res_valid is never asserted; a subsequent request works normally. rst_n low mid-SHIFT → immediate IDLE, res_valid=0, res_data=0.
